opb_register_bank: RTL and testbench
====================================

OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 Parameter C_BASEADDR, default 32'h01008300, first byte address of the slave window.
REQ-002 Parameter C_HIGHADDR, default 32'h010083FF, last byte address of the slave window.
REQ-003 Parameter C_NUM_REGS, default 4, range 1..64, number of 32-bit registers.
REQ-004 Parameter C_PULSE_MASK, default {C_NUM_REGS{1'b0}}, bit i set makes register i self-clearing (pulse mode).
REQ-005 Parameter C_RESET_VAL, default all zeros, width C_NUM_REGS*32, per-register reset value packed like user_data_out.
REQ-006 OPB_Clk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-007 OPB_Rst  in  1  synchronous, active-high reset.
REQ-008 OPB_ABus  in  [0:31]  byte address.
REQ-009 OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7] (MSB lane).
REQ-010 OPB_DBus  in  [0:31]  write data; bit 0 is the MSB.
REQ-011 OPB_RNW, OPB_select, OPB_seqAddr  in  1 each  read-not-write, transfer select, and sequential address (ignored).
REQ-012 Sl_DBus  out  [0:31]  read data.
REQ-013 Sl_xferAck  out  1  transfer acknowledge.
REQ-014 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
REQ-015 user_data_out  out  [C_NUM_REGS*32-1:0]  register i on bits [32i+31:32i], where OPB bit 0 maps to user bit 31.
REQ-016 user_wr_stb  out  [C_NUM_REGS-1:0]  one-cycle strobe per committed write.

Function
REQ-017 Hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; register index = OPB_ABus[2+] word offset from C_BASEADDR.
REQ-018 FSM states: IDLE, ACK, HOLD. Transitions are IDLE->ACK on hit, ACK->HOLD always, HOLD->IDLE when OPB_select = 0.
REQ-019 Sl_xferAck shall be 1 exactly in ACK: one cycle, the cycle after the hit is sampled, and never again until select drops.
REQ-020 A write shall commit on the edge entering ACK, only for lanes with BE set; unselected lanes are unchanged; user_data_out shows the new value in the ACK cycle.
REQ-021 user_wr_stb[i] shall be 1 in the ACK cycle of a write to index i, even with BE = 0000.
REQ-022 Reads: Sl_DBus = register[index] during ACK, 0 in all other cycles (OR-bus requirement).
REQ-023 Index >= C_NUM_REGS inside the window: ack as normal, read returns 0, write discarded, no strobe.
REQ-024 Pulse-mode register: the written value is visible for exactly the ACK cycle, then returns to 0 on the next edge; reads return its current value.
REQ-025 A write to a pulse register in consecutive transactions shall produce separate one-cycle pulses.
REQ-026 Addresses outside the window shall produce no ack, no write, and Sl_DBus = 0.

Reset
REQ-027 While OPB_Rst = 1 on an edge: FSM -> IDLE; Sl_xferAck, Sl_DBus and user_wr_stb -> 0; every register -> C_RESET_VAL slice.
REQ-028 Reset asserted in ACK or HOLD shall abort the transfer with no further ack; an in-flight write either committed before the reset edge or is lost, and reset values win.
REQ-029 After reset release with OPB_select still high, the bank shall treat it as a new hit.

Structure
REQ-030 Shared package opb_regbank_pkg shall hold the FSM state enum, the register width constant (32), and the C_NUM_REGS range limits.
REQ-031 Sub-module opb_regbank_addr_dec shall perform window compare and index extraction combinationally; the top-level module holds the FSM, registers, and muxes.

Verification
REQ-032 Write 0xDEADBEEF to 0x01008304 with BE = 1111, select held 3 cycles -> one ack in cycle 2, user_data_out[63:32] = 0xDEADBEEF, user_wr_stb = 0010.
REQ-033 Preload reg0 = 0x11223344, then write 0xAABBCCDD with BE = 0101 -> reg0 = 0x11BB33DD; read of 0x01008300 returns 0x11BB33DD on Sl_DBus only in the ack cycle.
REQ-034 With C_PULSE_MASK = 0001, write 0x1 to reg0 -> user_data_out[0] high for exactly 1 cycle, then 0; a read afterwards returns 0.
REQ-035 Access 0x01008340 (index 16 >= 4) -> ack, read 0, no register change; access 0x01008400 -> no ack.
REQ-036 Assert OPB_Rst in the ACK cycle of a write to reg2 with C_RESET_VAL reg2 = 0x5 -> ack drops next cycle, reg2 = 0x5, and a new transaction is accepted after release.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// opb_regbank_pkg: shared types and constants for the OPB register bank.
package opb_regbank_pkg;
    localparam int REG_W = 32;
    localparam int MIN_REGS = 1;
    localparam int MAX_REGS = 64;
    localparam int IDX_W = $clog2(MAX_REGS);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
endpackage

// File: rtl/opb_regbank_addr_dec.sv
// opb_regbank_addr_dec: window compare and register index extraction.
module opb_regbank_addr_dec import opb_regbank_pkg::*; #(
    parameter logic [31:0] C_BASEADDR = 32'h01008300,
    parameter logic [31:0] C_HIGHADDR = 32'h010083FF,
    parameter int C_NUM_REGS = 4
) (
    input  logic [0:31]      abus,
    input  logic             select,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    logic [31:0] addr;
    logic [31:0] off;
    logic [1:0] unused_off;
    assign addr = abus;
    assign off = addr - C_BASEADDR;
    assign unused_off = off[1:0];
    assign hit = select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
    assign idx = off[IDX_W+1:2];
    // validity uses the full word offset so large windows never alias onto low registers
    assign valid = off[31:2] < 30'(C_NUM_REGS);
endmodule

// File: rtl/opb_register_bank.sv
// opb_register_bank: OPB slave exposing C_NUM_REGS 32-bit registers with optional pulse mode.
module opb_register_bank import opb_regbank_pkg::*; #(
    parameter logic [31:0] C_BASEADDR = 32'h01008300,
    parameter logic [31:0] C_HIGHADDR = 32'h010083FF,
    parameter int C_NUM_REGS = 4,
    parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
    parameter logic [C_NUM_REGS*REG_W-1:0] C_RESET_VAL = '0
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    input  logic [0:31]                   OPB_ABus,
    input  logic [0:3]                    OPB_BE,
    input  logic [0:31]                   OPB_DBus,
    input  logic                          OPB_RNW,
    input  logic                          OPB_select,
    input  logic                          OPB_seqAddr,
    output logic [0:31]                   Sl_DBus,
    output logic                          Sl_xferAck,
    output logic                          Sl_errAck,
    output logic                          Sl_retry,
    output logic                          Sl_toutSup,
    output logic [C_NUM_REGS*REG_W-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]         user_wr_stb
);
    state_t state, state_n;
    logic hit, valid, start, wr_go, rnw_q, valid_q, unused_seq;
    logic [IDX_W-1:0] idx, idx_q;
    logic [31:0] wdata, rd_data;
    logic [3:0] be;

    opb_regbank_addr_dec #(
        .C_BASEADDR(C_BASEADDR),
        .C_HIGHADDR(C_HIGHADDR),
        .C_NUM_REGS(C_NUM_REGS)
    ) u_dec (
        .abus(OPB_ABus),
        .select(OPB_select),
        .hit(hit),
        .idx(idx),
        .valid(valid)
    );

    // OPB bit 0 is the MSB, so a plain assignment lands lane BE[0] on bits 31:24
    assign wdata = OPB_DBus;
    assign be = OPB_BE;
    assign unused_seq = OPB_seqAddr;
    assign start = state == IDLE && hit;
    assign wr_go = start && !OPB_RNW && valid;

    always_comb begin
        state_n = state;
        if (state == IDLE && hit) state_n = ACK;
        else if (state == ACK) state_n = HOLD;
        else if (state == HOLD && !OPB_select) state_n = IDLE;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state <= IDLE;
            user_data_out <= C_RESET_VAL;
            user_wr_stb <= '0;
            idx_q <= '0;
            rnw_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                idx_q <= idx;
                rnw_q <= OPB_RNW;
                valid_q <= valid;
            end
            for (int i = 0; i < C_NUM_REGS; i++) begin
                user_wr_stb[i] <= wr_go && idx == IDX_W'(i);
                if (C_PULSE_MASK[i]) user_data_out[i*REG_W +: REG_W] <= '0;
                if (wr_go && idx == IDX_W'(i))
                    for (int b = 0; b < 4; b++)
                        if (be[b]) user_data_out[i*REG_W + 8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (idx_q == IDX_W'(i)) rd_data = user_data_out[i*REG_W +: REG_W];
    end

    assign Sl_xferAck = state == ACK;
    assign Sl_DBus = (state == ACK && rnw_q && valid_q) ? rd_data : '0;
    assign Sl_errAck = 1'b0;
    assign Sl_retry = 1'b0;
    assign Sl_toutSup = 1'b0;
endmodule

// File: tb/tb_opb_register_bank.sv
// tb_opb_register_bank: directed and randomized OPB transfers checked against a transaction-level model.
module tb_opb_register_bank;
    localparam logic [31:0] BASE = 32'h01008300;
    localparam logic [31:0] HIGH = 32'h010083FF;
    localparam logic [3:0] PULSE = 4'b1000;
    localparam logic [127:0] RST_VAL = {32'h0, 32'h5, 32'hCAFE0001, 32'hA5A50000};

    logic clk = 0, rst = 1, sel = 0, rnw = 0, seq = 0;
    logic [0:31] abus = '0, dbus = '0;
    logic [0:3] be = '0;
    logic [0:31] sl_dbus;
    logic sl_ack, sl_err, sl_retry, sl_tout;
    logic [127:0] udata;
    logic [3:0] stb;

    opb_register_bank #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(4),
        .C_PULSE_MASK(PULSE), .C_RESET_VAL(RST_VAL)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry),
        .Sl_toutSup(sl_tout), .user_data_out(udata), .user_wr_stb(stb)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int cyc = 0, ack_cnt = 0, ack_cyc = 0, pulse_cnt = 0;
    logic [3:0] ack_stb;
    logic [31:0] ack_rd;
    logic [127:0] ack_data;
    logic prev_p = 0, started = 0;

    logic [31:0] m_regs [4];
    logic m_ack = 0, m_eng = 0, m_rnw = 0;
    logic [3:0] m_stb = 0;
    int m_idx = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // transaction-level reference: a transfer is either engaged (acked, awaiting select drop) or not
    always @(posedge clk) begin
        logic [31:0] a, d;
        logic was_ack, in_win;
        int ix;
        cyc++;
        started = 1;
        a = abus;
        d = dbus;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = RST_VAL[32*i +: 32];
            m_ack = 0; m_stb = 0; m_eng = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (PULSE[i]) m_regs[i] = 0;
            was_ack = m_ack;
            m_ack = 0;
            m_stb = 0;
            in_win = sel && a >= BASE && a <= HIGH;
            if (!m_eng && in_win) begin
                ix = int'((a - BASE) >> 2);
                m_eng = 1; m_ack = 1; m_rnw = rnw; m_idx = ix;
                if (!rnw && ix < 4) begin
                    m_stb[ix] = 1;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_regs[ix][31-8*b -: 8] = d[31-8*b -: 8];
                end
            end else if (m_eng && !was_ack && !sel) m_eng = 0;
        end
    end

    always @(negedge clk) if (started) begin
        logic [31:0] exp_rd;
        exp_rd = 0;
        if (m_ack && m_rnw && m_idx < 4) exp_rd = m_regs[m_idx];
        chk("ack", sl_ack, m_ack);
        chk("rdata", sl_dbus, exp_rd);
        chk("user_data", udata, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        chk("wr_stb", stb, m_stb);
        chk("tied", {sl_err, sl_retry, sl_tout}, 0);
        if (sl_ack) begin
            ack_cnt++; ack_cyc = cyc; ack_stb = stb; ack_rd = sl_dbus; ack_data = udata;
        end
        if (udata[96] && !prev_p) pulse_cnt++;
        prev_p = udata[96];
    end

    int a0, c0;
    task automatic xfer(input logic [31:0] a, d, input logic [3:0] b, input logic r, input int n, input int rst_at);
        @(negedge clk); #1;
        sel = 1; abus = a; dbus = d; be = b; rnw = r;
        a0 = ack_cnt; c0 = cyc;
        for (int j = 0; j < n; j++) begin
            rst = (j == rst_at);
            @(negedge clk); #1;
        end
        rst = 0; sel = 0;
    endtask

    initial begin
        logic [127:0] snap;
        int p0, kind;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_data", udata, RST_VAL);
        chk("reset_ack", sl_ack, 0);
        chk("reset_stb", stb, 0);

        xfer(32'h01008304, 32'hDEADBEEF, 4'b1111, 0, 3, -1);
        chk("w1_ack_count", ack_cnt - a0, 1);
        chk("w1_ack_cycle", ack_cyc - c0, 1);
        chk("w1_stb", ack_stb, 4'b0010);
        chk("w1_data", udata[63:32], 32'hDEADBEEF);

        xfer(BASE, 32'h11223344, 4'b1111, 0, 3, -1);
        xfer(BASE, 32'hAABBCCDD, 4'b0101, 0, 3, -1);
        chk("be_merge", udata[31:0], 32'h11BB33DD);
        xfer(BASE, 32'h0BADF00D, 4'b1111, 1, 3, -1);
        chk("be_read", ack_rd, 32'h11BB33DD);
        chk("be_read_after", sl_dbus, 0);

        p0 = pulse_cnt;
        xfer(BASE + 12, 32'h1, 4'b1111, 0, 3, -1);
        chk("pulse_in_ack", ack_data[127:96], 32'h1);
        chk("pulse_cleared", udata[127:96], 0);
        xfer(BASE + 12, 32'h1, 4'b1111, 0, 2, -1);
        chk("pulse_count", pulse_cnt - p0, 2);
        xfer(BASE + 12, 32'h0, 4'b1111, 1, 3, -1);
        chk("pulse_read", ack_rd, 0);

        snap = udata;
        xfer(BASE + 32'h40, 32'hFFFFFFFF, 4'b1111, 0, 3, -1);
        chk("oor_ack", ack_cnt - a0, 1);
        chk("oor_stb", ack_stb, 0);
        chk("oor_nochange", udata, snap);
        xfer(BASE + 32'h40, 32'h0, 4'b1111, 1, 3, -1);
        chk("oor_read", ack_rd, 0);
        xfer(32'h01008400, 32'h12345678, 4'b1111, 0, 3, -1);
        chk("miss_noack", ack_cnt - a0, 0);

        @(negedge clk); #1;
        sel = 1; abus = BASE + 8; dbus = 32'h77; be = 4'b1111; rnw = 0;
        @(negedge clk);
        chk("rst_in_ack_ack", sl_ack, 1);
        chk("rst_in_ack_commit", udata[95:64], 32'h77);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_abort_ack", sl_ack, 0);
        chk("rst_abort_val", udata[95:64], 32'h5);
        #1 rst = 0; dbus = 32'h99;
        @(negedge clk);
        chk("rst_rehit_ack", sl_ack, 1);
        chk("rst_rehit_val", udata[95:64], 32'h99);
        #1 sel = 0;
        @(negedge clk);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) a = BASE + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
            else if (kind == 6) a = BASE + 32'h10 + $urandom_range(0, 32'hEF);
            else if (kind == 7) a = BASE - 1 - $urandom_range(0, 32'hFF);
            else if (kind == 8) a = HIGH + 1 + $urandom_range(0, 32'hFF);
            else a = HIGH - $urandom_range(0, 3);
            xfer(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, 4),
                 ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
